dpll_zone_sequencer: RTL and testbench

Sequences the FluxRipper DPLL across seeks and Macintosh speed-zone transitions.
- On each seek completion, selects the nominal bit-cell period for the target track and zone.
- Pulses rate_change into the auto loop filter.
- Holds the filter off while the NCO settles, then supervises acquisition.
- Declares lock, lock loss, or lock failure.
- Sits between the drive/seek controller and the data separator (NCO plus loop filter).

---
 rtl/dpll_zone_sequencer_if.sv | 30 +++
 rtl/dpll_zone_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_dpll_zone_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dpll_zone_sequencer_if.sv
// Handshake bundle between the drive/seek controller, the sequencer and the data separator.
// The master drives the seek/phase-detector side; the slave is the sequencer itself.
interface dpll_zone_sequencer_if;
    logic        enable;
    logic        mac_mode;
    logic        seek_done;
    logic [6:0]  track;
    logic        error_valid;
    logic [1:0]  margin_zone;
    logic [15:0] nco_period;
    logic        rate_change;
    logic        lf_enable;
    logic        pll_locked;
    logic        lost_lock;
    logic        lock_fail;
    logic [2:0]  zone;
    logic [1:0]  retry_cnt;

    modport master (
        output enable, mac_mode, seek_done, track, error_valid, margin_zone,
        input  nco_period, rate_change, lf_enable, pll_locked, lost_lock, lock_fail, zone,
               retry_cnt
    );

    modport slave (
        input  enable, mac_mode, seek_done, track, error_valid, margin_zone,
        output nco_period, rate_change, lf_enable, pll_locked, lost_lock, lock_fail, zone,
               retry_cnt
    );
endinterface

// File: rtl/dpll_zone_sequencer.sv
// DPLL sequencer: loads the nominal bit-cell period per seek/zone, holds the loop filter off
// while the NCO settles, then supervises acquisition, lock, lock loss and retry exhaustion.
module dpll_zone_sequencer #(
    parameter logic [15:0] PERIOD_PC     = 16'd2000,
    parameter logic [15:0] PERIOD_Z0     = 16'd2600,
    parameter logic [15:0] PERIOD_Z1     = 16'd2383,
    parameter logic [15:0] PERIOD_Z2     = 16'd2166,
    parameter logic [15:0] PERIOD_Z3     = 16'd1950,
    parameter logic [15:0] PERIOD_Z4     = 16'd1733,
    parameter int unsigned SETTLE_CYCLES = 256,
    parameter int unsigned LOCK_COUNT    = 32,
    parameter int unsigned UNLOCK_COUNT  = 8,
    parameter int unsigned ACQ_TIMEOUT   = 4096,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    dpll_zone_sequencer_if.slave         bus
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StLoad    = 3'd1;
    localparam logic [2:0] StSettle  = 3'd2;
    localparam logic [2:0] StAcquire = 3'd3;
    localparam logic [2:0] StLocked  = 3'd4;
    localparam logic [2:0] StFail    = 3'd5;

    localparam int unsigned GoodW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned BadW  = $clog2(UNLOCK_COUNT + 1);

    localparam logic [15:0]      SettleLoad = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0]      AcqLimit   = 16'(ACQ_TIMEOUT);
    localparam logic [GoodW-1:0] LockLimit  = GoodW'(LOCK_COUNT);
    localparam logic [BadW-1:0]  BadLimit   = BadW'(UNLOCK_COUNT);
    localparam logic [1:0]       LastRetry  = 2'(MAX_RETRY - 1);

    logic [2:0]       state_q, state_d;
    logic [15:0]      nco_period_q, nco_period_d;
    logic [2:0]       zone_q, zone_d;
    logic [1:0]       retry_q, retry_d;
    logic             first_load_q, first_load_d;
    logic [15:0]      settle_q, settle_d;
    logic [15:0]      sample_q, sample_d;
    logic [GoodW-1:0] good_q, good_d;
    logic [BadW-1:0]  bad_q, bad_d;
    logic             rate_change_q, rate_change_d;
    logic             lost_lock_q, lost_lock_d;
    logic             lf_enable_q, lf_enable_d;
    logic             pll_locked_q, pll_locked_d;
    logic             lock_fail_q, lock_fail_d;

    logic [2:0]       dec_zone;
    logic [15:0]      dec_period;
    logic             on_time;
    logic [15:0]      sample_inc;
    logic [GoodW-1:0] good_inc;
    logic [BadW-1:0]  bad_inc;

    always_comb begin
        dec_zone   = 3'd0;
        dec_period = PERIOD_PC;
        if (bus.mac_mode) begin
            if (bus.track < 7'd16) begin
                dec_zone   = 3'd0;
                dec_period = PERIOD_Z0;
            end else if (bus.track < 7'd32) begin
                dec_zone   = 3'd1;
                dec_period = PERIOD_Z1;
            end else if (bus.track < 7'd48) begin
                dec_zone   = 3'd2;
                dec_period = PERIOD_Z2;
            end else if (bus.track < 7'd64) begin
                dec_zone   = 3'd3;
                dec_period = PERIOD_Z3;
            end else begin
                dec_zone   = 3'd4;
                dec_period = PERIOD_Z4;
            end
        end
    end

    assign on_time    = (bus.margin_zone == 2'b01);
    assign sample_inc = (sample_q == '1) ? sample_q : sample_q + 16'd1;
    assign good_inc   = (good_q == '1) ? good_q : good_q + 1'b1;
    assign bad_inc    = (bad_q == '1) ? bad_q : bad_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        nco_period_d  = nco_period_q;
        zone_d        = zone_q;
        retry_d       = retry_q;
        first_load_d  = first_load_q;
        settle_d      = settle_q;
        sample_d      = sample_q;
        good_d        = good_q;
        bad_d         = bad_q;
        rate_change_d = 1'b0;
        lost_lock_d   = 1'b0;

        if (!bus.enable) begin
            state_d = StIdle;
        end else if (bus.seek_done) begin
            // The period/zone are committed on entry so the LOAD cycle already presents them.
            state_d       = StLoad;
            nco_period_d  = dec_period;
            zone_d        = dec_zone;
            retry_d       = 2'd0;
            rate_change_d = first_load_q || (dec_period != nco_period_q);
            first_load_d  = 1'b0;
        end else begin
            case (state_q)
                StLoad: begin
                    state_d  = StSettle;
                    settle_d = SettleLoad;
                end
                StSettle: begin
                    if (settle_q == 16'd0) begin
                        state_d  = StAcquire;
                        sample_d = 16'd0;
                        good_d   = '0;
                        bad_d    = '0;
                    end else begin
                        settle_d = settle_q - 16'd1;
                    end
                end
                StAcquire: begin
                    if (bus.error_valid) begin
                        sample_d = sample_inc;
                        good_d   = on_time ? good_inc : '0;
                        if (good_d >= LockLimit) begin
                            state_d = StLocked;
                            bad_d   = '0;
                        end else if (sample_d >= AcqLimit) begin
                            if (retry_q == LastRetry) begin
                                state_d = StFail;
                            end else begin
                                retry_d       = retry_q + 2'd1;
                                state_d       = StLoad;
                                rate_change_d = 1'b1;
                            end
                        end
                    end
                end
                StLocked: begin
                    if (bus.error_valid) begin
                        bad_d = on_time ? '0 : bad_inc;
                        if (bad_d >= BadLimit) begin
                            state_d     = StAcquire;
                            lost_lock_d = 1'b1;
                            sample_d    = 16'd0;
                            good_d      = '0;
                            bad_d       = '0;
                            retry_d     = 2'd0;
                        end
                    end
                end
                default: ;
            endcase
        end

        // Status flags follow the state being entered so they are registered alongside it.
        lf_enable_d  = (state_d == StAcquire) || (state_d == StLocked);
        pll_locked_d = (state_d == StLocked);
        lock_fail_d  = (state_d == StFail);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            nco_period_q  <= PERIOD_PC;
            zone_q        <= 3'd0;
            retry_q       <= 2'd0;
            first_load_q  <= 1'b1;
            settle_q      <= 16'd0;
            sample_q      <= 16'd0;
            good_q        <= '0;
            bad_q         <= '0;
            rate_change_q <= 1'b0;
            lost_lock_q   <= 1'b0;
            lf_enable_q   <= 1'b0;
            pll_locked_q  <= 1'b0;
            lock_fail_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            nco_period_q  <= nco_period_d;
            zone_q        <= zone_d;
            retry_q       <= retry_d;
            first_load_q  <= first_load_d;
            settle_q      <= settle_d;
            sample_q      <= sample_d;
            good_q        <= good_d;
            bad_q         <= bad_d;
            rate_change_q <= rate_change_d;
            lost_lock_q   <= lost_lock_d;
            lf_enable_q   <= lf_enable_d;
            pll_locked_q  <= pll_locked_d;
            lock_fail_q   <= lock_fail_d;
        end
    end

    assign bus.nco_period  = nco_period_q;
    assign bus.rate_change = rate_change_q;
    assign bus.lf_enable   = lf_enable_q;
    assign bus.pll_locked  = pll_locked_q;
    assign bus.lost_lock   = lost_lock_q;
    assign bus.lock_fail   = lock_fail_q;
    assign bus.zone        = zone_q;
    assign bus.retry_cnt   = retry_q;

endmodule

// File: tb/tb_dpll_zone_sequencer.sv
// Self-checking bench for dpll_zone_sequencer: directed scenarios plus randomized traffic,
// every cycle compared against a phase-level reference model.
module tb_dpll_zone_sequencer;

    localparam int SETTLE  = 256;
    localparam int LOCK_N  = 32;
    localparam int UNLOCK_N = 8;
    localparam int TIMEOUT = 4096;
    localparam int RETRIES = 3;

    logic clk;
    logic rst;
    dpll_zone_sequencer_if bus ();

    dpll_zone_sequencer dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_passed;

    // Reference model state, kept as named phases and plain counts.
    string       m_phase;
    logic [15:0] m_period;
    int          m_zone;
    int          m_retry;
    bit          m_first;
    bit          m_rc;
    bit          m_ll;
    int          m_settle_left;
    int          m_samples;
    int          m_run;
    int          m_bad;
    logic [15:0] zone_period [5];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic void model_reset();
        m_phase  = "idle";
        m_period = 16'd2000;
        m_zone   = 0;
        m_retry  = 0;
        m_first  = 1'b1;
        m_rc     = 1'b0;
        m_ll     = 1'b0;
        m_samples = 0;
        m_run    = 0;
        m_bad    = 0;
        m_settle_left = 0;
    endfunction

    function automatic void model_edge();
        int z;
        logic [15:0] p;
        m_rc = 1'b0;
        m_ll = 1'b0;
        if (!bus.enable) begin
            m_phase = "idle";
        end else if (bus.seek_done) begin
            z = 0;
            p = 16'd2000;
            if (bus.mac_mode) begin
                z = (bus.track >= 7'd64) ? 4 : int'(bus.track) / 16;
                p = zone_period[z];
            end
            m_rc     = m_first || (p != m_period);
            m_first  = 1'b0;
            m_period = p;
            m_zone   = z;
            m_retry  = 0;
            m_phase  = "load";
        end else if (m_phase == "load") begin
            m_phase = "settle";
            m_settle_left = SETTLE;
        end else if (m_phase == "settle") begin
            if (m_settle_left == 1) begin
                m_phase = "acquire";
                m_samples = 0;
                m_run = 0;
            end else begin
                m_settle_left--;
            end
        end else if (m_phase == "acquire" && bus.error_valid) begin
            m_samples++;
            m_run = (bus.margin_zone == 2'b01) ? m_run + 1 : 0;
            if (m_run == LOCK_N) begin
                m_phase = "locked";
                m_bad = 0;
            end else if (m_samples == TIMEOUT) begin
                if (m_retry + 1 == RETRIES) m_phase = "fail";
                else begin
                    m_retry++;
                    m_phase = "load";
                    m_rc = 1'b1;
                end
            end
        end else if (m_phase == "locked" && bus.error_valid) begin
            m_bad = (bus.margin_zone == 2'b01) ? 0 : m_bad + 1;
            if (m_bad == UNLOCK_N) begin
                m_phase = "acquire";
                m_ll = 1'b1;
                m_samples = 0;
                m_run = 0;
                m_retry = 0;
            end
        end
    endfunction

    task automatic check_outputs(input string tag);
        logic [31:0] got;
        logic [31:0] exp;
        got = {6'd0, bus.nco_period, bus.zone, bus.retry_cnt, bus.rate_change, bus.lf_enable,
               bus.pll_locked, bus.lost_lock, bus.lock_fail};
        exp = {6'd0, m_period, 3'(m_zone), 2'(m_retry), m_rc,
               (m_phase == "acquire" || m_phase == "locked"), (m_phase == "locked"), m_ll,
               (m_phase == "fail")};
        check_eq($sformatf("%s_%s", tag, m_phase), got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        check_outputs("cyc");
    endtask

    function automatic logic [1:0] pick_bad();
        case ($urandom_range(0, 2))
            0:       return 2'b00;
            1:       return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    task automatic seek(input bit mac, input int trk);
        bus.mac_mode    = mac;
        bus.track       = 7'(trk);
        bus.error_valid = 1'b0;
        bus.seek_done   = 1'b1;
        step();
        bus.seek_done   = 1'b0;
    endtask

    // One phase-detector sample, preceded by a random number of idle cycles.
    task automatic sample(input logic [1:0] mz);
        bus.error_valid = 1'b0;
        repeat ($urandom_range(0, 2)) step();
        bus.error_valid = 1'b1;
        bus.margin_zone = mz;
        step();
        bus.error_valid = 1'b0;
    endtask

    // LOAD cycle is already visible; walk through SETTLE with junk samples that must be ignored.
    task automatic pass_settle();
        for (int i = 0; i < SETTLE + 1; i++) begin
            bus.error_valid = $urandom_range(0, 1);
            bus.margin_zone = 2'b01;
            step();
        end
        bus.error_valid = 1'b0;
    endtask

    initial begin
        int n;
        int good_pct;
        zone_period[0] = 16'd2600;
        zone_period[1] = 16'd2383;
        zone_period[2] = 16'd2166;
        zone_period[3] = 16'd1950;
        zone_period[4] = 16'd1733;
        n_checks = 0;
        n_passed = 0;
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.mac_mode = 1'b0;
        bus.seek_done = 1'b0;
        bus.track = 7'd0;
        bus.error_valid = 1'b0;
        bus.margin_zone = 2'b00;
        model_reset();
        #2;
        check_outputs("reset");
        repeat (2) step();
        rst = 1'b0;
        bus.enable = 1'b1;
        step();

        // First Mac load at zone 1, then count filter-off cycles after LOAD.
        seek(1'b1, 20);
        check_eq("tp1_period", 32'(bus.nco_period), 32'd2383);
        check_eq("tp1_zone", 32'(bus.zone), 32'd1);
        check_eq("tp1_rate_change", 32'(bus.rate_change), 32'd1);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (bus.lf_enable) break;
            n++;
        end
        check_eq("tp1_lf_low_cycles", 32'(n), 32'(SETTLE));
        check_eq("tp1_lf_on", 32'(bus.lf_enable), 32'd1);

        // 31 good then one early sample must not lock; a full good run must.
        for (int i = 0; i < LOCK_N - 1; i++) sample(2'b01);
        sample(pick_bad());
        check_eq("tp2_no_lock", 32'(bus.pll_locked), 32'd0);
        for (int i = 0; i < LOCK_N - 1; i++) sample(2'b01);
        check_eq("tp2_not_yet", 32'(bus.pll_locked), 32'd0);
        sample(2'b01);
        check_eq("tp2_locked", 32'(bus.pll_locked), 32'd1);

        // Same-zone seek keeps the period; a zone-4 seek changes it.
        seek(1'b1, 16 + $urandom_range(0, 15));
        check_eq("tp3_same_rc", 32'(bus.rate_change), 32'd0);
        check_eq("tp3_unlocked", 32'(bus.pll_locked), 32'd0);
        pass_settle();
        seek(1'b1, $urandom_range(64, 127));
        check_eq("tp3_z4_zone", 32'(bus.zone), 32'd4);
        check_eq("tp3_z4_period", 32'(bus.nco_period), 32'd1733);
        check_eq("tp3_z4_rc", 32'(bus.rate_change), 32'd1);
        pass_settle();

        // Lock, survive 7 bad + 1 good, then lose lock on 8 bad.
        for (int i = 0; i < LOCK_N; i++) sample(2'b01);
        check_eq("tp5_locked", 32'(bus.pll_locked), 32'd1);
        for (int i = 0; i < UNLOCK_N - 1; i++) sample(pick_bad());
        sample(2'b01);
        check_eq("tp5_holds", 32'(bus.pll_locked), 32'd1);
        for (int i = 0; i < UNLOCK_N; i++) sample(pick_bad());
        check_eq("tp5_lost_pulse", 32'(bus.lost_lock), 32'd1);
        check_eq("tp5_dropped", 32'(bus.pll_locked), 32'd0);
        check_eq("tp5_lf_on", 32'(bus.lf_enable), 32'd1);
        step();
        check_eq("tp5_pulse_end", 32'(bus.lost_lock), 32'd0);

        // Acquisition timeouts: two retries, then failure.
        seek(1'b1, 3);
        pass_settle();
        for (int r = 1; r <= RETRIES; r++) begin
            for (int i = 0; i < TIMEOUT; i++) begin
                bus.error_valid = 1'b1;
                bus.margin_zone = pick_bad();
                step();
            end
            if (r < RETRIES) begin
                check_eq($sformatf("tp4_retry%0d_rc", r), 32'(bus.rate_change), 32'd1);
                check_eq($sformatf("tp4_retry%0d_cnt", r), 32'(bus.retry_cnt), 32'(r));
                pass_settle();
            end
        end
        bus.error_valid = 1'b0;
        check_eq("tp4_fail", 32'(bus.lock_fail), 32'd1);
        check_eq("tp4_lf_off", 32'(bus.lf_enable), 32'd0);
        repeat (5) step();
        check_eq("tp4_fail_held", 32'(bus.lock_fail), 32'd1);

        // Async reset mid-SETTLE, enable=0 beating seek_done, and PC mode override.
        seek(1'b1, 40);
        repeat (10) step();
        #2 rst = 1'b1;
        #1 model_reset();
        check_outputs("async_reset");
        check_eq("tp6_reset_period", 32'(bus.nco_period), 32'd2000);
        step();
        rst = 1'b0;
        bus.enable = 1'b0;
        bus.mac_mode = 1'b1;
        bus.track = 7'd20;
        bus.seek_done = 1'b1;
        step();
        bus.seek_done = 1'b0;
        check_eq("tp6_en_beats_seek", 32'(bus.nco_period), 32'd2000);
        bus.enable = 1'b1;
        step();
        seek(1'b0, 70);
        check_eq("tp6_pc_period", 32'(bus.nco_period), 32'd2000);
        check_eq("tp6_pc_zone", 32'(bus.zone), 32'd0);
        check_eq("tp6_pc_rc", 32'(bus.rate_change), 32'd1);

        // Randomized traffic, alternating clean and noisy phase-error segments.
        for (int seg = 0; seg < 8; seg++) begin
            good_pct = (seg % 2 == 0) ? 97 : 40;
            for (int i = 0; i < 500; i++) begin
                bus.enable      = ($urandom_range(0, 399) != 0);
                bus.seek_done   = ($urandom_range(0, 249) == 0);
                bus.mac_mode    = $urandom_range(0, 1);
                bus.track       = 7'($urandom_range(0, 127));
                bus.error_valid = $urandom_range(0, 1);
                bus.margin_zone = ($urandom_range(0, 99) < good_pct) ? 2'b01 : pick_bad();
                step();
            end
            bus.enable    = 1'b1;
            bus.seek_done = 1'b0;
            seek($urandom_range(0, 1), $urandom_range(0, 127));
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
